// File: rtl/cmp_stream_tracker.sv
// cmp_stream_tracker
//   Frame statistics stage behind the 8-bit magnitude comparator. For each
//   accepted beat it counts the comparator result (gt/lt/eq/invalid) and tracks
//   the longest run of consecutive equal results. On the in_last beat the block
//   moves to a report state and holds the accumulators on its outputs until the
//   consumer takes them with out_valid/out_ready.
//
//   Optional feature macro: CMP_TRACK_MAX_EN
//     defined     -> max_val tracks the largest A or B seen in the frame
//     not defined -> no max register is built, max_val is tied to zero
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready input beat handshake (in_ready decoded from state only)
//   A, B              unsigned operands
//   cmp               comparator code: 00 eq, 01 gt, 10 lt, 11 invalid
//   in_last           accepted beat closes the frame
//   out_valid/out_ready report handshake
//   gt_cnt, lt_cnt, eq_cnt, err_cnt  saturating per-frame counts
//   eq_run_max        longest run of consecutive equal codes (saturating)
//   max_val           largest operand in the frame (see macro above)
//   err_flag          at least one invalid code seen in the frame

module cmp_stream_tracker #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic [1:0]       cmp,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] eq_run_max,
  output logic [7:0]       max_val,
  output logic             err_flag
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [1:0]       CMP_EQ  = 2'b00;
  localparam logic [1:0]       CMP_GT  = 2'b01;
  localparam logic [1:0]       CMP_LT  = 2'b10;
  localparam logic [1:0]       CMP_ERR = 2'b11;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;

  logic             w_accept;
  logic             w_consume;

  logic [CNT_W-1:0] r_gt_cnt;
  logic [CNT_W-1:0] r_lt_cnt;
  logic [CNT_W-1:0] r_eq_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_cur_run;
  logic [CNT_W-1:0] r_eq_run_max;
  logic             r_err_flag;

  logic [CNT_W-1:0] w_gt_nxt;
  logic [CNT_W-1:0] w_lt_nxt;
  logic [CNT_W-1:0] w_eq_nxt;
  logic [CNT_W-1:0] w_err_nxt;
  logic [CNT_W-1:0] w_run_nxt;
  logic [CNT_W-1:0] w_run_max_nxt;
  logic             w_err_flag_nxt;

  // Handshake qualifiers come straight from the state register so that
  // in_ready never combinationally depends on in_valid.
  always_comb begin
    w_accept  = 1'b0;
    w_consume = 1'b0;
    if (r_state == S_REPORT) begin
      w_consume = out_ready;
    end else begin
      w_accept  = in_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = in_last ? S_REPORT : S_ACCUM;
        end
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          w_state_nxt = S_REPORT;
        end
      end
      S_REPORT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-beat accumulator update
  // ---------------------------------------------------------------------------
  always_comb begin
    w_gt_nxt       = r_gt_cnt;
    w_lt_nxt       = r_lt_cnt;
    w_eq_nxt       = r_eq_cnt;
    w_err_nxt      = r_err_cnt;
    w_run_nxt      = '0;
    w_err_flag_nxt = r_err_flag;
    case (cmp)
      CMP_EQ: begin
        w_eq_nxt  = sat_inc(r_eq_cnt);
        w_run_nxt = sat_inc(r_cur_run);
      end
      CMP_GT:  w_gt_nxt = sat_inc(r_gt_cnt);
      CMP_LT:  w_lt_nxt = sat_inc(r_lt_cnt);
      CMP_ERR: begin
        w_err_nxt      = sat_inc(r_err_cnt);
        w_err_flag_nxt = 1'b1;
      end
      default: begin
        w_err_nxt = r_err_cnt;
      end
    endcase
    // Compare against the updated run so the current beat is included.
    w_run_max_nxt = (w_run_nxt > r_eq_run_max) ? w_run_nxt : r_eq_run_max;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gt_cnt     <= '0;
      r_lt_cnt     <= '0;
      r_eq_cnt     <= '0;
      r_err_cnt    <= '0;
      r_cur_run    <= '0;
      r_eq_run_max <= '0;
      r_err_flag   <= 1'b0;
    end else if (w_consume) begin
      r_gt_cnt     <= '0;
      r_lt_cnt     <= '0;
      r_eq_cnt     <= '0;
      r_err_cnt    <= '0;
      r_cur_run    <= '0;
      r_eq_run_max <= '0;
      r_err_flag   <= 1'b0;
    end else if (w_accept) begin
      r_gt_cnt     <= w_gt_nxt;
      r_lt_cnt     <= w_lt_nxt;
      r_eq_cnt     <= w_eq_nxt;
      r_err_cnt    <= w_err_nxt;
      r_cur_run    <= w_run_nxt;
      r_eq_run_max <= w_run_max_nxt;
      r_err_flag   <= w_err_flag_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional operand maximum
  // ---------------------------------------------------------------------------
`ifdef CMP_TRACK_MAX_EN
  logic [7:0] r_max_val;
  logic [7:0] w_beat_max;

  always_comb begin
    w_beat_max = (A > B) ? A : B;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max_val <= '0;
    end else if (w_consume) begin
      r_max_val <= '0;
    end else if (w_accept && (w_beat_max > r_max_val)) begin
      r_max_val <= w_beat_max;
    end
  end

  assign max_val = r_max_val;
`else
  assign max_val = 8'd0;
`endif

  assign gt_cnt     = r_gt_cnt;
  assign lt_cnt     = r_lt_cnt;
  assign eq_cnt     = r_eq_cnt;
  assign err_cnt    = r_err_cnt;
  assign eq_run_max = r_eq_run_max;
  assign err_flag   = r_err_flag;

endmodule

// File: tb/tb_cmp_stream_tracker.sv
// Scoreboard bench for cmp_stream_tracker (built with CNT_W=4 so saturation
// is reachable with short frames). Expected reports are computed from the
// list of beats of each frame and queued; a monitor pops and compares them
// when the DUT presents a report.
module tb_cmp_stream_tracker;

  localparam int unsigned CW   = 4;
  localparam int          CMAX = 15;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    A;
  logic [7:0]    B;
  logic [1:0]    cmp;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] gt_cnt;
  logic [CW-1:0] lt_cnt;
  logic [CW-1:0] eq_cnt;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] eq_run_max;
  logic [7:0]    max_val;
  logic          err_flag;

  cmp_stream_tracker #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .cmp        (cmp),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .gt_cnt     (gt_cnt),
    .lt_cnt     (lt_cnt),
    .eq_cnt     (eq_cnt),
    .err_cnt    (err_cnt),
    .eq_run_max (eq_run_max),
    .max_val    (max_val),
    .err_flag   (err_flag)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] c;
  } beat_t;

  typedef struct packed {
    logic [CW-1:0] gt;
    logic [CW-1:0] lt;
    logic [CW-1:0] eq;
    logic [CW-1:0] er;
    logic [CW-1:0] run;
    logic [7:0]    mx;
    logic          ef;
  } rep_t;

  beat_t frame_q[$];
  rep_t  exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    rdy_pct  = 60;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic int clampc(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  // Reference: statistics of a whole frame from its list of beats.
  function automatic rep_t model(input beat_t fr[$]);
    int   n_gt = 0, n_lt = 0, n_eq = 0, n_er = 0;
    int   run = 0, longest = 0, mx = 0;
    bit   ef = 0;
    rep_t r;
    foreach (fr[i]) begin
      if (fr[i].c == 2'b00) begin
        n_eq++;
        run++;
      end else begin
        run = 0;
        if (fr[i].c == 2'b01) n_gt++;
        else if (fr[i].c == 2'b10) n_lt++;
        else begin
          n_er++;
          ef = 1;
        end
      end
      if (run > longest) longest = run;
      if (int'(fr[i].a) > mx) mx = int'(fr[i].a);
      if (int'(fr[i].b) > mx) mx = int'(fr[i].b);
    end
`ifndef CMP_TRACK_MAX_EN
    mx = 0;
`endif
    r.gt  = CW'(clampc(n_gt));
    r.lt  = CW'(clampc(n_lt));
    r.eq  = CW'(clampc(n_eq));
    r.er  = CW'(clampc(n_er));
    r.run = CW'(clampc(longest));
    r.mx  = 8'(mx);
    r.ef  = ef;
    return r;
  endfunction

  function automatic rep_t dut_rep();
    rep_t r;
    r.gt  = gt_cnt;
    r.lt  = lt_cnt;
    r.eq  = eq_cnt;
    r.er  = err_cnt;
    r.run = eq_run_max;
    r.mx  = max_val;
    r.ef  = err_flag;
    return r;
  endfunction

  // Consumer: out_ready randomised just after each rising edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // Monitor: pops the expected report when one appears, checks it is held.
  initial begin
    rep_t cur;
    bit   have_cur = 0;
    bit   consumed = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_cur = 0;
        consumed = 0;
      end else begin
        if (consumed) begin
          chk("cleared_after_consume", int'(dut_rep()), 0);
          chk("in_ready_after_consume", int'(in_ready), 1);
          consumed = 0;
        end
        if (out_valid) begin
          chk("in_ready_low_in_report", int'(in_ready), 0);
          if (!have_cur) begin
            if (exp_q.size() == 0) begin
              fail_now("unexpected_report");
              cur = dut_rep();
            end else begin
              cur = exp_q.pop_front();
              chk("gt_cnt",     int'(gt_cnt),     int'(cur.gt));
              chk("lt_cnt",     int'(lt_cnt),     int'(cur.lt));
              chk("eq_cnt",     int'(eq_cnt),     int'(cur.eq));
              chk("err_cnt",    int'(err_cnt),    int'(cur.er));
              chk("eq_run_max", int'(eq_run_max), int'(cur.run));
              chk("max_val",    int'(max_val),    int'(cur.mx));
              chk("err_flag",   int'(err_flag),   int'(cur.ef));
            end
            have_cur = 1;
          end else begin
            chk("report_stable", int'(dut_rep()), int'(cur));
          end
          if (out_ready) begin
            consumed = 1;
            have_cur = 0;
          end
        end
      end
    end
  end

  // Issue one beat (called at a falling edge, returns at a falling edge).
  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] c, input logic last);
    bit    acc = 0;
    bit    rdy;
    int    waited = 0;
    beat_t bt;
    A = a; B = b; cmp = c; in_last = last; in_valid = 1'b1;
    while (!acc && waited < 100) begin
      rdy = in_ready;
      @(posedge clk);
      waited++;
      if (rdy) begin
        acc  = 1;
        bt.a = a; bt.b = b; bt.c = c;
        frame_q.push_back(bt);
        if (last) begin
          exp_q.push_back(model(frame_q));
          frame_q.delete();
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) fail_now("accept_timeout");
    else chk("out_valid_after_accept", int'(out_valid), int'(last));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || out_valid) fail_now("drain_timeout");
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_fields"},    int'(dut_rep()), 0);
    chk({tag, "_in_ready"},  int'(in_ready),  1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; cmp = '0; in_last = 1'b0;
    #3;
    check_reset_values("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Mixed frame.
    send(8'd4, 8'd5, 2'b10, 1'b0);
    send(8'd9, 8'd9, 2'b00, 1'b0);
    send(8'd10, 8'd8, 2'b01, 1'b0);
    send(8'd4, 8'd8, 2'b10, 1'b1);

    // Equal runs split by a gt, closed by an invalid code.
    send(8'd1, 8'd1, 2'b00, 1'b0);
    send(8'd2, 8'd2, 2'b00, 1'b0);
    send(8'd3, 8'd3, 2'b00, 1'b0);
    send(8'd9, 8'd3, 2'b01, 1'b0);
    send(8'd5, 8'd5, 2'b00, 1'b0);
    send(8'd6, 8'd6, 2'b00, 1'b0);
    send(8'd7, 8'd0, 2'b11, 1'b1);

    // Report held while upstream keeps offering a beat.
    drain();
    rdy_pct = 0;
    repeat (2) @(negedge clk);
    send(8'd20, 8'd30, 2'b10, 1'b0);
    send(8'd40, 8'd40, 2'b00, 1'b1);
    A = 8'd7; B = 8'd7; cmp = 2'b00; in_last = 1'b1; in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_out_valid", int'(out_valid), 1);
    end
    rdy_pct = 100;
    send(8'd7, 8'd7, 2'b00, 1'b1);
    rdy_pct = 60;

    // Saturation: 20 gt beats with 4-bit counters.
    for (int i = 0; i < 20; i++) send(8'(i + 1), 8'd0, 2'b01, (i == 19));
    // Saturation of equal count and run length.
    for (int i = 0; i < 18; i++) send(8'd3, 8'd3, 2'b00, (i == 17));

    // Asynchronous reset mid-frame.
    drain();
    send(8'd50, 8'd1, 2'b01, 1'b0);
    send(8'd2, 8'd2, 2'b00, 1'b0);
    send(8'd3, 8'd60, 2'b11, 1'b0);
    #2;
    rst_n = 1'b0;
    frame_q.delete();
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'd1, 8'd2, 2'b10, 1'b0);
    send(8'd3, 8'd3, 2'b00, 1'b1);

    // Single-beat frame with extreme operands.
    send(8'd255, 8'd0, 2'b01, 1'b1);

    // Random frames.
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        logic [1:0] c;
        c = $urandom_range(0, 1) ? 2'b00 : 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        send(8'($urandom), 8'($urandom), c, (i == len - 1));
      end
    end

    rdy_pct = 100;
    drain();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmp_stream_tracker.md
# cmp_stream_tracker

Frame-based statistics stage sitting directly downstream of the 8-bit magnitude comparator. Each beat carries the operand pair A/B plus the comparator's 2-bit result code. The block counts greater/less/equal/invalid results over a frame and tracks the longest run of consecutive equal results. At frame end it presents a registered report under a valid/ready handshake.

## Interface
Parameters:
- CNT_W, 8: width of each result counter and of the run-length register; all saturate at 2^CNT_W-1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  beat present on A/B/cmp/in_last.
- in_ready  out  1  block accepts a beat; beat accepted when in_valid && in_ready at a clk edge.
- A  in  8  operand A, unsigned.
- B  in  8  operand B, unsigned.
- cmp  in  2  comparator code: 2'b00 A==B, 2'b01 A>B, 2'b10 A<B, 2'b11 invalid.
- in_last  in  1  accepted beat is the final beat of the frame.
- out_valid  out  1  report fields are valid and held stable.
- out_ready  in  1  consumer takes the report; report consumed when out_valid && out_ready.
- gt_cnt, lt_cnt, eq_cnt, err_cnt  out  CNT_W each  per-frame result counts.
- eq_run_max  out  CNT_W  longest run of consecutive 2'b00 results in the frame.
- max_val  out  8  largest operand seen in the frame (see Configuration).
- err_flag  out  1  at least one 2'b11 code in the frame.

## Operation
- States: IDLE (no beat yet in frame), ACCUM (at least one beat accepted), REPORT (holding report).
- IDLE/ACCUM: in_ready=1. REPORT: in_ready=0. in_ready is decoded from state only and never depends on in_valid.
- Transitions:
  - IDLE->ACCUM on an accepted beat with in_last=0.
  - IDLE or ACCUM->REPORT on an accepted beat with in_last=1 (a single-beat frame is legal).
  - REPORT->IDLE on report consumed. All accumulators clear on that same edge.
- Per accepted beat:
  - Exactly one of gt/lt/eq/err counters increments, selected by cmp.
  - Each counter saturates; it never wraps.
- Equal-run tracking:
  - cur_run increments (saturating) on cmp=00.
  - cur_run clears to 0 on any other code, including 11.
  - eq_run_max = max(eq_run_max, updated cur_run), so the beat's own contribution is included.
- err_flag is a sticky OR of (cmp==2'b11) over the frame.
- cmp is trusted as given: the block does not recompute A vs B.
- Report outputs are the accumulator registers themselves. They are stable throughout REPORT.

## Timing
- Reset (async assert, synchronous-safe deassert by the environment) sets:
  - state=IDLE, in_ready=1, out_valid=0.
  - all counters, eq_run_max and max_val = 0; err_flag=0.
- Latency: out_valid rises on the clk edge that accepts the in_last beat, and is visible in the following cycle. The report includes that last beat.
- out_valid stays high until consumed. Report fields must not change while out_valid=1.
- Back-to-back frames:
  - The first beat of the next frame can be accepted in the cycle after consumption.
  - That gives one bubble cycle minimum per frame.
- in_valid while in REPORT is ignored (not accepted). The upstream holds its beat.
- Reset mid-frame or mid-REPORT: immediate return to reset values. Partial frame data is discarded.
- Saturated counter plus a further matching beat: the counter holds at 2^CNT_W-1.

## Configuration
- CMP_TRACK_MAX_EN defined:
  - max_val is a register updated per accepted beat to max(max_val, A, B).
  - Cleared on reset and on report consumption.
- Not defined:
  - No max register is built; max_val is tied to 8'd0.
  - All other behaviour is identical.

## Test plan
- Reset then frame (A,B,cmp) = (4,5,10),(9,9,00),(10,8,01),(4,8,10,last) -> report lt=2, eq=1, gt=1, err=0, eq_run_max=1, max_val=10 (0 if macro off), out_valid 1 cycle after last accept.
- Frame of cmp codes 00,00,00,01,00,00,last 11 -> eq=5, gt=1, err=1, err_flag=1, eq_run_max=3.
- Hold out_ready=0 for 10 cycles in REPORT with in_valid=1 -> in_ready=0, no beat accepted, report stable. Then out_ready=1 -> IDLE, counters 0, next frame accepted the following cycle.
- CNT_W=4, frame of 20 beats cmp=01 -> gt_cnt=15 (saturated), others 0.
- Assert rst_n=0 asynchronously mid-frame after 3 beats -> outputs reach reset values without a clock edge. The next frame reports only its own beats.
- Single-beat frame (A=255, B=0, cmp=01, last) -> gt=1, max_val=255, eq_run_max=0.
